// File: rtl/traffic_request_conditioner.sv
// Synchronizes, debounces and latches four vehicle-sensor lines into held requests.
// A request clears when the controller serves its approach. Each waiting request gets an urgency flag.
module traffic_request_conditioner #(
  parameter logic [15:0] DB_CYCLES  = 16'd50_000,
  parameter logic [23:0] WAIT_LIMIT = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sensor_raw,
  input  logic       serve_valid,
  input  logic [1:0] serve_dir,
  output logic [3:0] req_status,
  output logic [3:0] urgent,
  output logic [3:0] sensor_db,
  output logic [2:0] pending_count
);

  localparam logic [15:0] DB_LAST = DB_CYCLES - 16'd1;

  logic [3:0] r_s1;
  logic [3:0] r_s2;
  logic [3:0] w_db;
  logic [3:0] w_req;
  logic [3:0] w_urgent;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 4'b0000;
      r_s2 <= 4'b0000;
    end else begin
      r_s1 <= sensor_raw;
      r_s2 <= r_s1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    localparam logic [1:0] LANE = 2'(g);

    logic        r_db;
    logic [15:0] r_db_cnt;
    logic        r_req;
    logic [23:0] r_wait_cnt;
    logic        w_db_fire;
    logic        w_set;
    logic        w_clr;

    assign w_db_fire = (r_s2[g] != r_db) && (r_db_cnt == DB_LAST);
    // A debounced rise always re-arms the lane, even when it lands on a serve.
    assign w_set     = w_db_fire && r_s2[g];
    assign w_clr     = serve_valid && (serve_dir == LANE);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_db     <= 1'b0;
        r_db_cnt <= 16'd0;
      end else if (r_s2[g] == r_db) begin
        r_db_cnt <= 16'd0;
      end else if (w_db_fire) begin
        r_db     <= r_s2[g];
        r_db_cnt <= 16'd0;
      end else begin
        r_db_cnt <= r_db_cnt + 16'd1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_req <= 1'b0;
      end else if (w_set) begin
        r_req <= 1'b1;
      end else if (w_clr) begin
        r_req <= 1'b0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_wait_cnt <= 24'd0;
      end else if (w_set || w_clr) begin
        r_wait_cnt <= 24'd0;
      end else if (r_req && (r_wait_cnt != WAIT_LIMIT)) begin
        r_wait_cnt <= r_wait_cnt + 24'd1;
      end
    end

    assign w_db[g]     = r_db;
    assign w_req[g]    = r_req;
    assign w_urgent[g] = r_req && (r_wait_cnt == WAIT_LIMIT);
  end

  assign sensor_db     = w_db;
  assign req_status    = w_req;
  assign urgent        = w_urgent;
  assign pending_count = {2'b00, w_req[0]} + {2'b00, w_req[1]}
                       + {2'b00, w_req[2]} + {2'b00, w_req[3]};

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Directed bench for traffic_request_conditioner with DB_CYCLES=4, WAIT_LIMIT=20.
module tb_traffic_request_conditioner;

  logic       clk;
  logic       reset;
  logic [3:0] sensor_raw;
  logic       serve_valid;
  logic [1:0] serve_dir;
  logic [3:0] req_status;
  logic [3:0] urgent;
  logic [3:0] sensor_db;
  logic [2:0] pending_count;

  int n_checks;
  int n_fail;

  traffic_request_conditioner #(
    .DB_CYCLES (16'd4),
    .WAIT_LIMIT(24'd20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sensor_raw   (sensor_raw),
    .serve_valid  (serve_valid),
    .serve_dir    (serve_dir),
    .req_status   (req_status),
    .urgent       (urgent),
    .sensor_db    (sensor_db),
    .pending_count(pending_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic serve(input logic [1:0] dir);
    serve_valid = 1'b1;
    serve_dir   = dir;
    tick();
    serve_valid = 1'b0;
    serve_dir   = 2'd0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    sensor_raw  = 4'b0000;
    serve_valid = 1'b0;
    serve_dir   = 2'd0;
    ticks(2);
    chk("rst_req", 32'(req_status), 32'h0);
    chk("rst_urgent", 32'(urgent), 32'h0);
    chk("rst_db", 32'(sensor_db), 32'h0);
    chk("rst_count", 32'(pending_count), 32'h0);
    reset = 1'b0;

    // Clean press on lane 0: visible at edge 6, not before.
    tick();
    sensor_raw = 4'b0001;
    ticks(5);
    chk("press_db_e5", 32'(sensor_db), 32'h0);
    chk("press_req_e5", 32'(req_status), 32'h0);
    tick();
    chk("press_db_e6", 32'(sensor_db), 32'h1);
    chk("press_req_e6", 32'(req_status), 32'h1);
    chk("press_count", 32'(pending_count), 32'h1);

    // Three-cycle glitch on lane 2 is rejected.
    sensor_raw = 4'b0101;
    ticks(3);
    sensor_raw = 4'b0001;
    ticks(8);
    chk("glitch_db", 32'(sensor_db), 32'h1);
    chk("glitch_req", 32'(req_status), 32'h1);

    // Four stable cycles are accepted.
    sensor_raw = 4'b0101;
    ticks(4);
    sensor_raw = 4'b0001;
    ticks(2);
    chk("stable4_db", 32'(sensor_db), 32'h5);
    chk("stable4_req", 32'(req_status), 32'h5);
    ticks(10);
    chk("stable4_db_fall", 32'(sensor_db), 32'h1);
    chk("stable4_req_held", 32'(req_status), 32'h5);

    // Serve lanes 0 and 2; lane 0 sensor still high must not re-request.
    serve(2'd0);
    chk("srv0_req", 32'(req_status), 32'h4);
    chk("srv0_count", 32'(pending_count), 32'h1);
    serve(2'd2);
    chk("srv2_req", 32'(req_status), 32'h0);
    ticks(8);
    chk("no_rereq", 32'(req_status), 32'h0);

    // Lanes 1 and 3 request, serve 3, idle serve on 0, then urgency on lane 1.
    sensor_raw = 4'b1010;
    ticks(5);
    chk("l13_req_e5", 32'(req_status), 32'h0);
    tick();
    chk("l13_req_e6", 32'(req_status), 32'ha);
    chk("l13_count", 32'(pending_count), 32'h2);
    serve(2'd3);
    chk("srv3_req", 32'(req_status), 32'h2);
    chk("srv3_count", 32'(pending_count), 32'h1);
    serve(2'd0);
    chk("idle_srv_req", 32'(req_status), 32'h2);
    chk("idle_srv_count", 32'(pending_count), 32'h1);
    ticks(17);
    chk("urg_e25", 32'(urgent), 32'h0);
    tick();
    chk("urg_e26", 32'(urgent), 32'h2);
    ticks(4);
    chk("urg_held", 32'(urgent), 32'h2);
    serve(2'd1);
    chk("urg_clr_urgent", 32'(urgent), 32'h0);
    chk("urg_clr_req", 32'(req_status), 32'h0);

    // Lane 0: request, debounced fall, then rise colliding with a serve.
    sensor_raw = 4'b1011;
    ticks(6);
    chk("col_set", 32'(req_status), 32'h1);
    sensor_raw = 4'b1010;
    ticks(6);
    chk("col_db_fall", 32'(sensor_db), 32'ha);
    chk("col_req_held", 32'(req_status), 32'h1);
    sensor_raw = 4'b1011;
    ticks(5);
    serve(2'd0);
    chk("col_req", 32'(req_status), 32'h1);
    chk("col_db", 32'(sensor_db), 32'hb);
    ticks(8);
    chk("col_no_old_urg", 32'(urgent), 32'h0);
    ticks(11);
    chk("col_urg_e37", 32'(urgent), 32'h0);
    tick();
    chk("col_urg_e38", 32'(urgent), 32'h1);

    // Asynchronous reset between edges, mid-debounce with a request pending.
    sensor_raw = 4'b1111;
    ticks(3);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_req", 32'(req_status), 32'h0);
    chk("arst_urgent", 32'(urgent), 32'h0);
    chk("arst_db", 32'(sensor_db), 32'h0);
    chk("arst_count", 32'(pending_count), 32'h0);
    ticks(2);
    reset = 1'b0;
    ticks(5);
    chk("post_rst_e5", 32'(req_status), 32'h0);
    tick();
    chk("post_rst_req", 32'(req_status), 32'hf);
    chk("post_rst_db", 32'(sensor_db), 32'hf);
    chk("post_rst_count", 32'(pending_count), 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_request_conditioner.md
# traffic_request_conditioner

Upstream conditioning stage for the 4-way traffic controller. Takes four raw, asynchronous vehicle-sensor lines, synchronizes and debounces them, and latches one request per approach. Each request stays asserted until the controller reports that approach served. Outputs drive the controller's 4-bit request inputs, plus per-lane urgency flags and a pending count for display and debug.

## Interface
Parameters:
- DB_CYCLES, 16'd50_000, consecutive stable cycles required to accept a sensor level change (legal range 1..65535)
- WAIT_LIMIT, 24'd10_000_000, cycles a request may pend before its urgent flag asserts (legal range 1..2^24-1)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- sensor_raw  input  4  raw vehicle detectors, bit i = approach i, asynchronous to clk
- serve_valid  input  1  one-cycle pulse from controller: approach serve_dir has been given green
- serve_dir  input  2  approach index qualified by serve_valid
- req_status  output  4  latched requests, bit i = approach i waiting
- urgent  output  4  bit i high when req_status[i] has pended WAIT_LIMIT cycles
- sensor_db  output  4  debounced sensor levels
- pending_count  output  3  number of set bits in req_status (0..4)

## Operation
- Reset values: all outputs 0, synchronizer flops 0, debounce and wait counters 0.
- Synchronizer: each lane has a 2-flop synchronizer (s1, s2). Only s2 is used downstream.
- Debounce, per lane:
  - 16-bit counter db_cnt.
  - If s2 == sensor_db[i], db_cnt clears.
  - Otherwise, if db_cnt == DB_CYCLES-1, sensor_db[i] <= s2 and db_cnt <= 0.
  - Otherwise db_cnt increments.
  - A glitch shorter than DB_CYCLES cycles never reaches sensor_db.
- Request latch, per lane:
  - set_i = sensor_db[i] flipping 0->1 on this edge.
  - clr_i = serve_valid && serve_dir == i.
  - set_i has priority over clr_i, so a simultaneous arrival stays latched.
  - An already-set request is unaffected by further set_i.
  - A vehicle still present at serve time counts as served. No re-request occurs until the debounced level falls and rises again.
- Wait/urgency, per lane:
  - 24-bit wait_cnt, zeroed on set_i and on clr_i.
  - While req_status[i]=1, wait_cnt increments and saturates at WAIT_LIMIT.
  - urgent[i] = req_status[i] && wait_cnt == WAIT_LIMIT (registered compare or equivalent; must match the timing below).
- pending_count is the combinational popcount of the req_status register.
- serve_valid with no request pending on serve_dir is legal and has no effect.

## Timing
- Sensor to request latency: a sensor_raw rise that is stable from edge E0 sets s2 at E0+2. sensor_db[i] and req_status[i] then rise together at E0+1+DB_CYCLES+1 = E0+DB_CYCLES+2.
- Serve to clear latency: serve_valid sampled at edge E clears req_status[i] and urgent[i] at E, so both are visible low the following cycle.
- Urgency timing: urgent[i] rises WAIT_LIMIT edges after the edge that set req_status[i]. It stays high until that lane is cleared.
- Mid-operation reset: an assertion at any time clears everything immediately, with no dependence on clk. After release, a sensor already high is treated as a new rise and produces a request after the full latency.
- Counter limits: db_cnt never exceeds DB_CYCLES-1, and wait_cnt never wraps.

## Test plan
Run the bench with DB_CYCLES=4 and WAIT_LIMIT=20.
- Clean press: hold sensor_raw=4'b0001 from edge 0. Expect sensor_db[0] and req_status=4'b0001 at edge 6, and pending_count=1.
- Glitch reject: pulse sensor_raw[2] high for 3 cycles. Expect sensor_db and req_status to stay 0. Then repeat with 4 stable cycles and expect the request to latch.
- Serve clear: with req_status=4'b1010, pulse serve_valid with serve_dir=3. Expect req_status=4'b0010 next cycle and pending_count 2->1. A serve on idle lane 0 changes nothing.
- Urgency: latch lane 1 and never serve it. Expect urgent=4'b0010 exactly 20 edges after the request set, held thereafter. A serve then drops urgent and req_status together.
- Set/clear collision: make sensor_db[0] rise on the same edge as serve_valid with serve_dir=0. Expect req_status[0]=1 with wait_cnt restarted, so urgent[0] arrives 20 edges later.
- Async reset: assert reset mid-debounce with requests pending, between clock edges. Expect all outputs 0 immediately. Release with sensor_raw=4'b1111 held and expect req_status=4'b1111 after DB_CYCLES+2 edges.
